// File: rtl/spec_free_list_param.sv
// Speculative physical-register free list: circular FIFO of free tags with compacted
// multi-lane pop/push and head checkpoints. Define FREELIST_DUP_CHECK_EN for duplicate-push detection.
module spec_free_list_param #(
   parameter int DISPATCH_WIDTH = 4,
   parameter int COMMIT_WIDTH   = 4,
   parameter int FL_DEPTH       = 32,
   parameter int PHYS_LOG       = 6,
   parameter int INIT_BASE      = 32,
   parameter int NUM_CKPT       = 4,
   localparam int CKPT_LOG      = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
   localparam int CNT_W         = $clog2(FL_DEPTH + 1),
   localparam int IDX_W         = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               stall_i,
   input  logic [DISPATCH_WIDTH-1:0]          req_i,
   output logic [DISPATCH_WIDTH*PHYS_LOG-1:0] free_reg_o,
   output logic [DISPATCH_WIDTH-1:0]          free_valid_o,
   output logic                               alloc_ok_o,
   input  logic [COMMIT_WIDTH-1:0]            commit_valid_i,
   input  logic [COMMIT_WIDTH*PHYS_LOG-1:0]   commit_reg_i,
   input  logic                               ckpt_we_i,
   input  logic [CKPT_LOG-1:0]                ckpt_id_i,
   input  logic                               recover_br_i,
   input  logic [CKPT_LOG-1:0]                recover_id_i,
   input  logic                               recover_all_i,
   output logic [CNT_W-1:0]                   count_o,
   output logic [IDX_W-1:0]                   head_o,
   output logic                               overflow_err_o,
   output logic                               dup_err_o
);
   localparam int SW = IDX_W + 1;
   typedef logic [PHYS_LOG-1:0] tag_t;
   typedef logic [IDX_W-1:0]    idx_t;

   tag_t             mem_q [FL_DEPTH];
   tag_t             mem_d [FL_DEPTH];
   idx_t             ckpt_q [NUM_CKPT];
   idx_t             head_q, head_d, tail_q, tail_d, ckpt_rd;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d, alloc, recov, ckpt_wr;
   logic [SW-1:0]    diff;
   int               n_req, n_pop, n_push, n_acc, room;
   logic [DISPATCH_WIDTH-1:0]               grant;
   logic [DISPATCH_WIDTH-1:0][PHYS_LOG-1:0] lane_tag;

   // Single conditional subtract is enough since a < FL_DEPTH and b <= FL_DEPTH.
   function automatic idx_t mod_add(input idx_t a, input int b);
      logic [SW-1:0] s;
      s = {1'b0, a} + SW'(b);
      if (s >= SW'(FL_DEPTH)) s = s - SW'(FL_DEPTH);
      return s[IDX_W-1:0];
   endfunction

   function automatic int below(input logic [DISPATCH_WIDTH-1:0] v, input int k);
      int n;
      n = 0;
      for (int j = 0; j < k; j++) n += int'(v[j]);
      return n;
   endfunction

   always_comb begin : c_alloc
      n_req = 0;
      for (int k = 0; k < DISPATCH_WIDTH; k++) n_req += int'(req_i[k]);
      recov      = recover_all_i | recover_br_i;
      alloc_ok_o = int'(count_q) >= n_req;
      alloc      = ~stall_i & ~recov & alloc_ok_o;
      n_pop      = alloc ? n_req : 0;
   end

   for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_lane
      assign grant[k]    = req_i[k] & alloc;
      assign lane_tag[k] = grant[k] ? mem_q[mod_add(head_q, below(req_i, k))] : '0;
   end
   assign free_valid_o = grant;
   assign free_reg_o   = lane_tag;

   always_comb begin : c_push
      int r;
      n_push = 0;
      for (int j = 0; j < COMMIT_WIDTH; j++) n_push += int'(commit_valid_i[j]);
      room  = FL_DEPTH - (int'(count_q) - n_pop);
      n_acc = (n_push > room) ? room : n_push;
      ovf_d = ovf_q | (n_push > room);
      mem_d = mem_q;
      r     = 0;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         if (commit_valid_i[j]) begin
            if (r < n_acc) mem_d[mod_add(tail_q, r)] = commit_reg_i[j*PHYS_LOG +: PHYS_LOG];
            r++;
         end
      end
      tail_d = mod_add(tail_q, n_acc);
   end

   always_comb begin : c_next
      ckpt_rd = (int'(recover_id_i) < NUM_CKPT) ? ckpt_q[recover_id_i] : '0;
      ckpt_wr = 1'b0;
      diff    = '0;
      head_d  = head_q;
      count_d = count_q;
      if (recover_all_i) begin
         head_d  = tail_d;
         count_d = CNT_W'(FL_DEPTH);
      end else if (recover_br_i) begin
         head_d = ckpt_rd;
         diff   = {1'b0, tail_d} + SW'(FL_DEPTH) - {1'b0, ckpt_rd};
         if (diff >= SW'(FL_DEPTH)) diff = diff - SW'(FL_DEPTH);
         // Zero distance is ambiguous: treat as a full window unless the list was truly empty.
         if (diff == '0 && (count_q != '0 || n_acc != 0)) count_d = CNT_W'(FL_DEPTH);
         else                                              count_d = CNT_W'(diff);
      end else begin
         head_d  = mod_add(head_q, n_pop);
         count_d = CNT_W'(int'(count_q) - n_pop + n_acc);
         ckpt_wr = ckpt_we_i & (int'(ckpt_id_i) < NUM_CKPT);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < FL_DEPTH; i++) mem_q[i] <= tag_t'(INIT_BASE + i);
         for (int i = 0; i < NUM_CKPT; i++) ckpt_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= CNT_W'(FL_DEPTH);
         ovf_q   <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         if (ckpt_wr) ckpt_q[ckpt_id_i] <= head_d;
      end
   end

   assign count_o        = count_q;
   assign head_o         = head_q;
   assign overflow_err_o = ovf_q;

`ifdef FREELIST_DUP_CHECK_EN
   logic [2**PHYS_LOG-1:0] inlist_q, inlist_d;
   logic                   dup_q, dup_d;

   always_comb begin : c_dup
      int            r;
      tag_t          t;
      logic [SW-1:0] off;
      inlist_d = inlist_q;
      dup_d    = dup_q;
      for (int k = 0; k < DISPATCH_WIDTH; k++)
         if (grant[k]) inlist_d[lane_tag[k]] = 1'b0;
      r = 0;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         if (commit_valid_i[j]) begin
            if (r < n_acc) begin
               t = commit_reg_i[j*PHYS_LOG +: PHYS_LOG];
               if (inlist_q[t]) dup_d = 1'b1;
               inlist_d[t] = 1'b1;
            end
            r++;
         end
      end
      // Recovery hands the whole restored window back to the list.
      if (recov) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            off = {1'b0, idx_t'(i)} + SW'(FL_DEPTH) - {1'b0, head_d};
            if (off >= SW'(FL_DEPTH)) off = off - SW'(FL_DEPTH);
            if (int'(off) < int'(count_d)) inlist_d[mem_d[i]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         inlist_q <= '0;
         for (int i = 0; i < FL_DEPTH; i++) inlist_q[tag_t'(INIT_BASE + i)] <= 1'b1;
         dup_q <= 1'b0;
      end else begin
         inlist_q <= inlist_d;
         dup_q    <= dup_d;
      end
   end
   assign dup_err_o = dup_q;
`else
   assign dup_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_spec_free_list_param.sv
// Bench for spec_free_list_param: directed plan steps then random traffic against a
// circular-array reference model.
module tb_spec_free_list_param;
   localparam int DW = 4, CW = 4, FL = 32, PL = 6, IB = 32, NC = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              stall;
   logic [DW-1:0]     req;
   logic [DW*PL-1:0]  free_reg;
   logic [DW-1:0]     free_valid;
   logic              alloc_ok;
   logic [CW-1:0]     cv;
   logic [CW*PL-1:0]  creg;
   logic              ckpt_we;
   logic [1:0]        ckpt_id;
   logic              rbr;
   logic [1:0]        rid;
   logic              rall;
   logic [5:0]        count;
   logic [4:0]        head;
   logic              ovf;
   logic              dup;

   spec_free_list_param #(.DISPATCH_WIDTH(DW), .COMMIT_WIDTH(CW), .FL_DEPTH(FL),
                          .PHYS_LOG(PL), .INIT_BASE(IB), .NUM_CKPT(NC)) dut (
      .clk(clk), .reset(reset), .stall_i(stall), .req_i(req),
      .free_reg_o(free_reg), .free_valid_o(free_valid), .alloc_ok_o(alloc_ok),
      .commit_valid_i(cv), .commit_reg_i(creg), .ckpt_we_i(ckpt_we), .ckpt_id_i(ckpt_id),
      .recover_br_i(rbr), .recover_id_i(rid), .recover_all_i(rall),
      .count_o(count), .head_o(head), .overflow_err_o(ovf), .dup_err_o(dup));

   always #5 clk = ~clk;

   int nchecks = 0, nerr = 0;
   int m_mem [FL];
   int m_ckpt [NC];
   int m_head, m_tail, m_cnt;
   bit m_ovf;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < FL; i++) m_mem[i] = IB + i;
      for (int i = 0; i < NC; i++) m_ckpt[i] = 0;
      m_head = 0; m_tail = 0; m_cnt = FL; m_ovf = 0;
   endtask

   function automatic bit m_alloc();
      return !stall && !rall && !rbr && (m_cnt >= $countones(req));
   endfunction

   // Compare combinational grants and current state against the model, mid-cycle.
   task automatic check_comb();
      logic [DW-1:0]    ev;
      logic [DW*PL-1:0] er;
      int               rank;
      @(negedge clk);
      ev = '0; er = '0; rank = 0;
      for (int k = 0; k < DW; k++) begin
         if (req[k]) begin
            if (m_alloc()) begin
               ev[k] = 1'b1;
               er[k*PL +: PL] = PL'(m_mem[(m_head + rank) % FL]);
            end
            rank++;
         end
      end
      chk("free_valid", free_valid, ev);
      chk("free_reg", free_reg, er);
      chk("alloc_ok", alloc_ok, m_cnt >= $countones(req));
      chk("count", count, m_cnt);
      chk("head", head, m_head);
      chk("overflow", ovf, m_ovf);
   endtask

   task automatic advance();
      int q[$];
      int pops, room, acc, c;
      @(posedge clk);
      pops = m_alloc() ? $countones(req) : 0;
      for (int j = 0; j < CW; j++) if (cv[j]) q.push_back(int'(creg[j*PL +: PL]));
      room = FL - (m_cnt - pops);
      acc  = (q.size() > room) ? room : q.size();
      if (q.size() > room) m_ovf = 1;
      for (int j = 0; j < acc; j++) m_mem[(m_tail + j) % FL] = q[j];
      m_tail = (m_tail + acc) % FL;
      if (rall) begin
         m_head = m_tail; m_cnt = FL;
      end else if (rbr) begin
         c = m_ckpt[rid];
         m_head = c;
         m_cnt = (m_tail - c + FL) % FL;
         if (m_cnt == 0 && (pops + acc + (m_cnt == 0 ? 0 : 1) >= 0) && (acc > 0 || count != 0)) m_cnt = FL;
      end else begin
         m_head = (m_head + pops) % FL;
         m_cnt  = m_cnt - pops + acc;
         if (ckpt_we) m_ckpt[ckpt_id] = m_head;
      end
      #1;
   endtask

   task automatic step();
      check_comb();
      advance();
   endtask

   task automatic idle();
      stall = 0; req = '0; cv = '0; creg = '0; ckpt_we = 0; ckpt_id = '0;
      rbr = 0; rid = '0; rall = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
      chk("rst_count", count, FL);
      chk("rst_head", head, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_dup", dup, 0);
   endtask

   initial begin
      reset = 1'b0;
      idle();
      // 1: four-wide pop from reset
      do_reset();
      req = 4'b1111;
      check_comb();
      chk("t1_lane0", free_reg[0 +: PL], 32);
      chk("t1_lane3", free_reg[3*PL +: PL], 35);
      advance();
      chk("t1_count", count, 28);
      chk("t1_head", head, 4);

      // 2: sparse request compaction, then all-or-nothing failure
      do_reset();
      req = 4'b1010;
      check_comb();
      chk("t2_valid", free_valid, 4'b1010);
      chk("t2_lane1", free_reg[1*PL +: PL], 32);
      chk("t2_lane3", free_reg[3*PL +: PL], 33);
      chk("t2_lane0", free_reg[0 +: PL], 0);
      advance();
      req = 4'b1111;
      for (int i = 0; i < 7; i++) step();
      req = 4'b0001;
      step();
      req = 4'b0011;
      check_comb();
      chk("t2_alloc_ok", alloc_ok, 0);
      chk("t2_nogrant", free_valid, 0);
      advance();
      chk("t2_count", count, 1);

      // 3: head wrap with pushes landing at the tail wrap
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 7; i++) step();
      req = 4'b0011;
      step();
      req = '0;
      for (int c = 0; c < 8; c++) begin
         cv = (c < 7) ? 4'b1111 : 4'b0011;
         for (int j = 0; j < CW; j++) creg[j*PL +: PL] = PL'(32 + 4*c + j);
         step();
      end
      chk("t3_count", count, 32);
      chk("t3_head", head, 30);
      req = 4'b1111; cv = 4'b0101;
      creg = '0; creg[0 +: PL] = 6'd40; creg[2*PL +: PL] = 6'd41;
      check_comb();
      chk("t3_lane0", free_reg[0 +: PL], 62);
      chk("t3_lane1", free_reg[1*PL +: PL], 63);
      chk("t3_lane2", free_reg[2*PL +: PL], 32);
      chk("t3_lane3", free_reg[3*PL +: PL], 33);
      advance();
      chk("t3_head2", head, 2);
      idle();
      req = 4'b1111;
      for (int i = 0; i < 8; i++) step();   // drains through entries 30/31 = 40/41

      // 4: checkpoint after pops, branch recovery
      do_reset();
      req = 4'b1111; ckpt_we = 1; ckpt_id = 2;
      step();
      ckpt_we = 0;
      step(); step();
      chk("t4_head12", head, 12);
      req = 4'b1111; rbr = 1; rid = 2;
      check_comb();
      chk("t4_nogrant", free_valid, 0);
      advance();
      chk("t4_head", head, 4);
      chk("t4_count", count, 28);

      // 5: everything at once; full flush wins, checkpoint write dropped
      rall = 1; rbr = 1; rid = 2; ckpt_we = 1; ckpt_id = 2; req = 4'b1111;
      check_comb();
      chk("t5_nogrant", free_valid, 0);
      advance();
      chk("t5_head", head, 0);
      chk("t5_count", count, 32);
      idle();
      rbr = 1; rid = 2;
      step();
      chk("t5_slot_kept", head, 4);
      chk("t5_count2", count, 28);

      // 6: push into a full list
      do_reset();
      cv = 4'b0001; creg = 24'd5;
      step();
      chk("t6_ovf", ovf, 1);
      chk("t6_count", count, 32);
      idle();
      req = 4'b1111;
      for (int i = 0; i < 8; i++) step();   // entry 0 must still hold 32
`ifdef FREELIST_DUP_CHECK_EN
      do_reset();
      req = 4'b0001;
      step();
      idle();
      cv = 4'b0001; creg = 24'd33;
      step();
      chk("t6_dup", dup, 1);
`else
      chk("t6_dup_tied", dup, 0);
`endif

      // Random traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         req     = DW'($urandom);
         stall   = ($urandom_range(0, 7) == 0);
         cv      = CW'($urandom) & CW'($urandom | $urandom);
         creg    = (DW*PL)'($urandom);
         ckpt_we = ($urandom_range(0, 2) == 0);
         ckpt_id = 2'($urandom);
         rbr     = ($urandom_range(0, 11) == 0);
         rid     = 2'($urandom);
         rall    = ($urandom_range(0, 39) == 0);
         step();
      end
      idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end
endmodule

// File: doc/spec_free_list_param.md
Name: spec_free_list_param

Overview:
Parametrised speculative physical-register free list for the rename stage, replacing the fixed 4-wide version. It is a circular FIFO of free physical tags:
- up to DISPATCH_WIDTH pops per cycle, compacted onto requesting lanes;
- up to COMMIT_WIDTH pushes per cycle from retire, compacted;
- an internal NUM_CKPT-entry head checkpoint table for branch-mispredict recovery.
Allocation is all-or-nothing against the actual request count, not against DISPATCH_WIDTH.

Parameters:
DISPATCH_WIDTH, 4, rename lanes / max pops per cycle
COMMIT_WIDTH, 4, retire lanes / max pushes per cycle
FL_DEPTH, 32, free-list entries; need not be a power of 2; >= DISPATCH_WIDTH
PHYS_LOG, 6, physical tag width
INIT_BASE, 32, reset content: entry i = INIT_BASE+i
NUM_CKPT, 4, checkpoint slots; CKPT_LOG = clog2(NUM_CKPT)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
stall_i  in  1  rename stall; blocks pops only
req_i  in  DISPATCH_WIDTH  per-lane allocate request
free_reg_o  in/out=out  DISPATCH_WIDTH*PHYS_LOG  lane k tag (lane k at bits [k*PHYS_LOG +: PHYS_LOG])
free_valid_o  out  DISPATCH_WIDTH  lane k granted
alloc_ok_o  out  1  count >= popcount(req_i)
commit_valid_i  in  COMMIT_WIDTH  per-lane push valid
commit_reg_i  in  COMMIT_WIDTH*PHYS_LOG  tags being freed
ckpt_we_i  in  1  save head into slot ckpt_id_i
ckpt_id_i  in  CKPT_LOG  save slot
recover_br_i  in  1  restore head from slot recover_id_i
recover_id_i  in  CKPT_LOG  restore slot
recover_all_i  in  1  full flush: head := tail
count_o  out  clog2(FL_DEPTH+1)  free entries
head_o  out  clog2(FL_DEPTH)  current head index
overflow_err_o  out  1  sticky; push would exceed FL_DEPTH

Behaviour:
Reset (reset==0 at posedge):
- head=tail=0, count=FL_DEPTH, entry i=INIT_BASE+i;
- ckpt slots=0, overflow_err_o=0.
Combinational outputs: free_valid_o, free_reg_o, alloc_ok_o.
- P = popcount(req_i); alloc = ~stall_i & (count>=P).
- Lane k granted iff req_i[k] & alloc. Granted lane k reads entry (head + popcount(req_i[k-1:0])) mod FL_DEPTH.
- Ungranted lanes drive free_reg_o=0.
- alloc_ok_o ignores stall_i.
Pushes:
- Valid lanes compacted in ascending lane order, written to (tail+j) mod FL_DEPTH.
- tail += popcount(commit_valid_i) every cycle, regardless of stall or recovery.
- If count - pops + pushes > FL_DEPTH: excess pushes dropped, tail advances only by accepted pushes, overflow_err_o set.
Index arithmetic:
- All mod-FL_DEPTH sums computed at width clog2(FL_DEPTH)+1, with a single conditional subtract.
Priority, highest first; one action per cycle:
1. recover_all_i: head := tail_next, count := FL_DEPTH - (entries not yet pushed back)... simplified: count := FL_DEPTH, matching current machine semantics of whole-window flush. No pops. ckpt write dropped.
2. recover_br_i: head := ckpt[recover_id_i]; count := (tail_next - ckpt + FL_DEPTH) mod FL_DEPTH. If that result is 0 and the pre-recovery count was nonzero or pushes occurred, count := FL_DEPTH. No pops. ckpt write dropped.
3. Normal cycle: head := head + granted pops (mod); count := count - pops + accepted pushes. If ckpt_we_i: ckpt[ckpt_id_i] := head_next, i.e. the value after this cycle's pops.
Stall or failed alloc: head holds; count += pushes.
Latency:
- Grant is same-cycle combinational.
- A pushed tag is poppable from the next cycle.
- Restored head is effective the next cycle.

Optional Feature:
FREELIST_DUP_CHECK_EN.
- Defined: adds a per-physical-tag "in list" bit vector, 2^PHYS_LOG bits.
  - Reset sets the bits for INIT_BASE..INIT_BASE+FL_DEPTH-1.
  - Pop clears a tag's bit; push sets it.
  - recover_br_i / recover_all_i re-set bits for every entry in [restored head, tail_next).
  - Pushing a tag whose bit is already set raises sticky output dup_err_o; the push is still performed.
- Undefined: dup_err_o exists and is tied 0; no bit vector.

Test Plan:
Defaults used throughout.
1. Reset, req_i=4'b1111 -> free_valid_o=1111, tags 32,33,34,35; next cycle count_o=28, head_o=4.
2. req_i=4'b1010 -> lane1=32, lane3=33, lanes0/2 valid=0 tag 0. Then count=1 with req_i=4'b0011 -> alloc_ok_o=0, no grants, count unchanged.
3. head=30, count=32, req=1111 -> tags 62,63,32,33; head_o=2. With commit_valid_i=0101 and commit_reg_i lanes 0/2 = 40/41 at tail=30: entries 30,31 = 40,41, tail=0.
4. ckpt_we_i, id=2 on a 4-pop cycle from head=0 -> slot2=4. Pop 8 more (head=12). recover_br_i id=2 with tail_next=0 -> head_o=4, count_o=28.
5. Same cycle: recover_all_i=1, recover_br_i=1, ckpt_we_i=1, req=1111 -> head=tail_next, count=32, no grants, ckpt slot unchanged.
6. count=32, one push -> overflow_err_o=1, tail unchanged. With FREELIST_DUP_CHECK_EN: pushing tag 33 while it is in the list -> dup_err_o=1.
